// File: rtl/ptmch_trg_mc.sv
// Multi-channel SPI NAND command pattern-match trigger.
// Captures the opcode+address header of each SPI frame and fires per-channel trigger pulses.
module ptmch_trg_mc #(
  parameter int NUM_CH   = 5,
  parameter int OP_W     = 8,
  parameter int ADDR_W   = 24,
  parameter int PLS_W    = 4,
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic                       CLK160M,
  input  logic                       RESET_N,
  input  logic                       SPI_CS,
  input  logic                       SPI_CLK,
  input  logic                       SPI_MOSI,
  input  logic [NUM_CH-1:0]          CH_EN,
  input  logic [NUM_CH*OP_W-1:0]     CH_OPCODE,
  input  logic [NUM_CH*OP_W-1:0]     CH_OPMASK,
  input  logic [NUM_CH*ADDR_W-1:0]   CH_LOW_ADDR,
  input  logic [NUM_CH*ADDR_W-1:0]   CH_HIGH_ADDR,
  input  logic [NUM_CH*PLS_W-1:0]    CH_PLS_LEN,
  input  logic                       ARM_MODE,
  input  logic                       REARM,
  input  logic                       HIT_CNT_CLR,
  output logic [NUM_CH-1:0]          TRG_PLS,
  output logic                       TRG_ANY,
  output logic [NUM_CH*CNT_W-1:0]    HIT_CNT,
  output logic                       FRAME_SHORT
);

  localparam int FRAME_W = OP_W + ADDR_W;
  localparam int BC_W    = $clog2(FRAME_W + 1);
  localparam logic [BC_W-1:0] FRAME_CNT = BC_W'(FRAME_W);
  localparam logic [BC_W-1:0] LAST_CNT  = BC_W'(FRAME_W - 1);

  logic [SYNC_STG-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                cs_d, sclk_d;
  logic                cs_s, sclk_s, mosi_s;
  logic                cs_fall, cs_rise, sclk_rise;

  logic [FRAME_W-1:0]  shift_reg;
  logic [BC_W-1:0]     bit_cnt;
  logic                hdr_vld;
  logic                frame_short_q;

  logic [OP_W-1:0]     hdr_op;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [NUM_CH-1:0]   match;
  logic [NUM_CH-1:0]   armed;
  logic [NUM_CH-1:0]   trg;
  logic [PLS_W-1:0]    pls_cnt [NUM_CH];
  logic [CNT_W-1:0]    hit_cnt [NUM_CH];

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STG-2:0], SPI_CS};
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], SPI_CLK};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], SPI_MOSI};
      cs_d      <= cs_sync[SYNC_STG-1];
      sclk_d    <= sclk_sync[SYNC_STG-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STG-1];
  assign sclk_s    = sclk_sync[SYNC_STG-1];
  assign mosi_s    = mosi_sync[SYNC_STG-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  // bit_cnt parks at FRAME_W so only the first header of a CS assertion is compared
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_reg     <= '0;
      bit_cnt       <= '0;
      hdr_vld       <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      hdr_vld       <= 1'b0;
      frame_short_q <= 1'b0;
      if (cs_fall) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (cs_rise) begin
        if (bit_cnt != '0 && bit_cnt < FRAME_CNT) begin
          frame_short_q <= 1'b1;
          shift_reg     <= '0;
        end
      end else if (!cs_s && sclk_rise && bit_cnt < FRAME_CNT) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
        bit_cnt   <= bit_cnt + BC_W'(1);
        if (bit_cnt == LAST_CNT) hdr_vld <= 1'b1;
      end
    end
  end

  assign hdr_op   = shift_reg[FRAME_W-1 -: OP_W];
  assign hdr_addr = shift_reg[ADDR_W-1:0];

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      match[i] = hdr_vld && CH_EN[i] && (armed[i] || !ARM_MODE)
              && (((hdr_op ^ CH_OPCODE[i*OP_W +: OP_W]) & CH_OPMASK[i*OP_W +: OP_W]) == '0)
              && (hdr_addr >= CH_LOW_ADDR[i*ADDR_W +: ADDR_W])
              && (hdr_addr <= CH_HIGH_ADDR[i*ADDR_W +: ADDR_W]);
    end
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      armed <= '1;
      trg   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pls_cnt[i] <= '0;
        hit_cnt[i] <= '0;
      end
    end else begin
      if (REARM)         armed <= '1;
      else if (ARM_MODE) armed <= armed & ~match;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (match[i]) begin
          pls_cnt[i] <= CH_PLS_LEN[i*PLS_W +: PLS_W];
          trg[i]     <= 1'b1;
        end else if (trg[i]) begin
          if (pls_cnt[i] == '0) trg[i]     <= 1'b0;
          else                  pls_cnt[i] <= pls_cnt[i] - PLS_W'(1);
        end
        if (HIT_CNT_CLR)                       hit_cnt[i] <= '0;
        else if (match[i] && hit_cnt[i] != '1) hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    HIT_CNT = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) HIT_CNT[i*CNT_W +: CNT_W] = hit_cnt[i];
  end

  assign TRG_PLS     = trg;
  assign TRG_ANY     = |trg;
  assign FRAME_SHORT = frame_short_q;

endmodule

// File: tb/tb_ptmch_trg_mc.sv
// Self-checking bench for ptmch_trg_mc: directed and randomized SPI frames against a header-level model.
module tb_ptmch_trg_mc;
  localparam int NUM_CH = 5;
  localparam int SYNC_STG = 2;
  localparam int LAT = SYNC_STG + 2;   // drive of last SPI_CLK rise -> first TRG_PLS cycle

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, spi_cs, spi_clk, spi_mosi, arm_mode, rearm, hit_clr;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*8-1:0]  ch_opcode, ch_opmask, ch_pls_len_b;
  logic [NUM_CH*24-1:0] ch_low, ch_high;
  logic [NUM_CH*4-1:0]  ch_pls_len;
  logic [NUM_CH-1:0]    trg_a, trg_b;
  logic                 any_a, any_b, fs_a, fs_b;
  logic [NUM_CH*16-1:0] hit_a;
  logic [NUM_CH*2-1:0]  hit_b;

  bit         c_en  [NUM_CH];
  logic [7:0]  c_op [NUM_CH];
  logic [7:0]  c_msk[NUM_CH];
  logic [23:0] c_lo [NUM_CH];
  logic [23:0] c_hi [NUM_CH];
  logic [3:0]  c_len[NUM_CH];
  logic [7:0]  c_len_b[NUM_CH];

  always_comb begin
    ch_en = '0; ch_opcode = '0; ch_opmask = '0; ch_low = '0; ch_high = '0;
    ch_pls_len = '0; ch_pls_len_b = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_en[i]               = c_en[i];
      ch_opcode[i*8 +: 8]    = c_op[i];
      ch_opmask[i*8 +: 8]    = c_msk[i];
      ch_low[i*24 +: 24]     = c_lo[i];
      ch_high[i*24 +: 24]    = c_hi[i];
      ch_pls_len[i*4 +: 4]   = c_len[i];
      ch_pls_len_b[i*8 +: 8] = c_len_b[i];
    end
  end

  ptmch_trg_mc dut_a (
    .CLK160M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk), .SPI_MOSI(spi_mosi),
    .CH_EN(ch_en), .CH_OPCODE(ch_opcode), .CH_OPMASK(ch_opmask), .CH_LOW_ADDR(ch_low),
    .CH_HIGH_ADDR(ch_high), .CH_PLS_LEN(ch_pls_len), .ARM_MODE(arm_mode), .REARM(rearm),
    .HIT_CNT_CLR(hit_clr), .TRG_PLS(trg_a), .TRG_ANY(any_a), .HIT_CNT(hit_a), .FRAME_SHORT(fs_a)
  );

  ptmch_trg_mc #(.CNT_W(2), .PLS_W(8)) dut_b (
    .CLK160M(clk), .RESET_N(rst_n), .SPI_CS(spi_cs), .SPI_CLK(spi_clk), .SPI_MOSI(spi_mosi),
    .CH_EN(ch_en), .CH_OPCODE(ch_opcode), .CH_OPMASK(ch_opmask), .CH_LOW_ADDR(ch_low),
    .CH_HIGH_ADDR(ch_high), .CH_PLS_LEN(ch_pls_len_b), .ARM_MODE(arm_mode), .REARM(rearm),
    .HIT_CNT_CLR(hit_clr), .TRG_PLS(trg_b), .TRG_ANY(any_b), .HIT_CNT(hit_b), .FRAME_SHORT(fs_b)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int hit_m[NUM_CH];
  int hit_mb;
  bit armed_m[NUM_CH];

  // observation of the outputs, sampled 1 time unit after each rising edge
  int cyc = 0;
  int rise_a[NUM_CH], hi_a[NUM_CH], last_rise_a[NUM_CH];
  int rise_b0 = 0, hi_b0 = 0, last_rise_b0 = 0, fs_cnt = 0, any_bad = 0;
  logic [NUM_CH-1:0] prev_a = '0;
  logic prev_b0 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trg_a[i] && !prev_a[i]) begin rise_a[i]++; last_rise_a[i] = cyc; end
      if (trg_a[i]) hi_a[i]++;
    end
    if (trg_b[0] && !prev_b0) begin rise_b0++; last_rise_b0 = cyc; end
    if (trg_b[0]) hi_b0++;
    prev_a  = trg_a;
    prev_b0 = trg_b[0];
    if (fs_a) fs_cnt++;
    if (any_a !== |trg_a || any_b !== |trg_b) any_bad++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit model_match(input int ch, input logic [31:0] f);
    logic [7:0]  op;
    logic [23:0] ad;
    op = f[31:24];
    ad = f[23:0];
    if (!c_en[ch]) return 1'b0;
    if (arm_mode && !armed_m[ch]) return 1'b0;
    for (int b = 0; b < 8; b++)
      if (c_msk[ch][b] && op[b] != c_op[ch][b]) return 1'b0;
    return (ad >= c_lo[ch]) && (ad <= c_hi[ch]);
  endfunction

  // Drives one CS assertion carrying the first nbits of f; k = cycle of the last SPI_CLK rise drive.
  task automatic send_frame(input logic [31:0] f, input int nbits, input bit clr_e1, output int k);
    k = cyc;
    spi_cs = 1'b0;
    tick(3);
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = f[31-b];
      tick(3);
      spi_clk = 1'b1;
      if (b == nbits - 1) k = cyc;
      tick(3);
      if (clr_e1 && b == nbits - 1) begin
        hit_clr = 1'b1;
        tick(1);
        hit_clr = 1'b0;
      end
      spi_clk = 1'b0;
    end
    tick(3);
    spi_cs = 1'b1;
    tick(3);
  endtask

  task automatic model_commit(input bit ex[NUM_CH]);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ex[ch]) begin
        if (hit_m[ch] < 65535) hit_m[ch]++;
        if (arm_mode) armed_m[ch] = 1'b0;
      end
    end
    if (ex[0] && hit_mb < 3) hit_mb++;
  endtask

  task automatic check_counts(input string tag);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (hit_a[ch*16 +: 16] !== 16'(hit_m[ch])) begin
        errors++;
        $display("FAIL %s hit_cnt[%0d]: got %0d, required %0d", tag, ch, hit_a[ch*16 +: 16], hit_m[ch]);
      end
    end
    checks++;
    if (hit_b[1:0] !== 2'(hit_mb)) begin
      errors++;
      $display("FAIL %s hit_cnt_w2[0]: got %0d, required %0d", tag, hit_b[1:0], hit_mb);
    end
  endtask

  task automatic run_frame(input logic [31:0] f, input bit clr_e1, input string tag);
    int k, fs0;
    int r0[NUM_CH], h0[NUM_CH];
    bit ex[NUM_CH];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ex[ch] = model_match(ch, f);
      r0[ch] = rise_a[ch];
      h0[ch] = hi_a[ch];
    end
    fs0 = fs_cnt;
    send_frame(f, 32, clr_e1, k);
    tick(20);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (rise_a[ch] - r0[ch] !== int'(ex[ch])) begin
        errors++;
        $display("FAIL %s pulses[%0d] frame %h: got %0d, required %0d", tag, ch, f, rise_a[ch] - r0[ch], ex[ch]);
      end
      if (ex[ch]) begin
        checks++;
        if (last_rise_a[ch] !== k + LAT) begin
          errors++;
          $display("FAIL %s rise_cycle[%0d]: got %0d, required %0d", tag, ch, last_rise_a[ch], k + LAT);
        end
        checks++;
        if (hi_a[ch] - h0[ch] !== int'(c_len[ch]) + 1) begin
          errors++;
          $display("FAIL %s width[%0d]: got %0d, required %0d", tag, ch, hi_a[ch] - h0[ch], int'(c_len[ch]) + 1);
        end
      end
    end
    checks++;
    if (fs_cnt !== fs0) begin
      errors++;
      $display("FAIL %s frame_short on full frame: got %0d cycles, required 0", tag, fs_cnt - fs0);
    end
    checks++;
    if (any_bad !== 0) begin
      errors++;
      $display("FAIL %s trg_any: got %0d bad cycles, required 0", tag, any_bad);
    end
    model_commit(ex);
    if (clr_e1) begin
      for (int ch = 0; ch < NUM_CH; ch++) hit_m[ch] = 0;
      hit_mb = 0;
    end
    check_counts(tag);
  endtask

  task automatic set_ch(input int ch, input bit en, input logic [7:0] op, input logic [7:0] msk,
                        input logic [23:0] lo, input logic [23:0] hi, input logic [3:0] len);
    c_en[ch] = en; c_op[ch] = op; c_msk[ch] = msk; c_lo[ch] = lo; c_hi[ch] = hi;
    c_len[ch] = len; c_len_b[ch] = 8'(len);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin hit_m[ch] = 0; armed_m[ch] = 1'b1; end
    hit_mb = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (trg_a !== '0 || any_a !== 1'b0 || fs_a !== 1'b0 || trg_b !== '0 || any_b !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got trg=%b any=%b fs=%b trg_w2=%b, required all 0", tag, trg_a, any_a, fs_a, trg_b);
    end
    checks++;
    if (hit_a !== '0 || hit_b !== '0) begin
      errors++;
      $display("FAIL %s counters: got %h / %h, required 0", tag, hit_a, hit_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    model_reset();
    tick(5);
    check_all_zero("reset_released");
  endtask

  task automatic test_basic();
    set_ch(0, 1, 8'h10, 8'hFF, 24'h000100, 24'h0001FF, 4'd15);
    run_frame(32'h10000150, 0, "basic");
  endtask

  task automatic test_window();
    run_frame(32'h100000FF, 0, "win_below");
    run_frame(32'h10000100, 0, "win_low");
    run_frame(32'h100001FF, 0, "win_high");
    run_frame(32'h10000200, 0, "win_above");
  endtask

  task automatic test_mask();
    set_ch(1, 1, 8'h00, 8'hF0, 24'h000000, 24'hFFFFFF, 4'd3);
    set_ch(2, 1, 8'h0F, 8'h00, 24'h800000, 24'h000010, 4'd5);
    run_frame(32'h0F123456, 0, "mask_hit");
    run_frame(32'h1F123456, 0, "mask_miss");
    run_frame(32'h0F000005, 0, "inverted_window");
  endtask

  task automatic test_short_frame();
    int k, fs0;
    int r0[NUM_CH];
    for (int ch = 0; ch < NUM_CH; ch++) r0[ch] = rise_a[ch];
    fs0 = fs_cnt;
    send_frame(32'h10000150, 20, 0, k);
    tick(20);
    checks++;
    if (fs_cnt - fs0 !== 1) begin
      errors++;
      $display("FAIL short frame_short: got %0d cycles, required 1", fs_cnt - fs0);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++;
      if (rise_a[ch] !== r0[ch]) begin
        errors++;
        $display("FAIL short pulses[%0d]: got %0d, required 0", ch, rise_a[ch] - r0[ch]);
      end
    end
    check_counts("short");
    run_frame(32'h10000150, 0, "after_short");
  endtask

  task automatic test_one_shot();
    arm_mode = 1'b1;
    tick(1);
    run_frame(32'h10000150, 0, "oneshot_first");
    run_frame(32'h10000160, 0, "oneshot_disarmed");
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) armed_m[ch] = 1'b1;
    run_frame(32'h10000170, 0, "oneshot_rearmed");
    arm_mode = 1'b0;
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) armed_m[ch] = 1'b1;
  endtask

  task automatic test_back_to_back();
    int k1, k2, r0, h0;
    bit ex1[NUM_CH], ex2[NUM_CH];
    c_len_b[0] = 8'd255;
    tick(1);
    r0 = rise_b0;
    h0 = hi_b0;
    for (int ch = 0; ch < NUM_CH; ch++) ex1[ch] = model_match(ch, 32'h10000180);
    send_frame(32'h10000180, 32, 0, k1);
    model_commit(ex1);
    for (int ch = 0; ch < NUM_CH; ch++) ex2[ch] = model_match(ch, 32'h10000190);
    send_frame(32'h10000190, 32, 0, k2);
    model_commit(ex2);
    tick(270);
    checks++;
    if (rise_b0 - r0 !== 1) begin
      errors++;
      $display("FAIL extend rises: got %0d, required 1", rise_b0 - r0);
    end
    checks++;
    if (last_rise_b0 !== k1 + LAT) begin
      errors++;
      $display("FAIL extend rise_cycle: got %0d, required %0d", last_rise_b0, k1 + LAT);
    end
    checks++;
    if (hi_b0 - h0 !== (k2 - k1) + 256) begin
      errors++;
      $display("FAIL extend width: got %0d, required %0d", hi_b0 - h0, (k2 - k1) + 256);
    end
    check_counts("extend");
    c_len_b[0] = 8'(c_len[0]);
  endtask

  task automatic test_saturate();
    hit_clr = 1'b1;
    tick(1);
    hit_clr = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) hit_m[ch] = 0;
    hit_mb = 0;
    tick(1);
    check_counts("clear");
    for (int n = 0; n < 5; n++) run_frame(32'h10000100 + 32'(n), 0, "saturate");
    run_frame(32'h100001AA, 1, "clear_wins");
  endtask

  task automatic test_random();
    logic [31:0] f;
    logic [23:0] ad;
    int j;
    for (int it = 0; it < 12; it++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c_en[ch]  = ($urandom_range(3) != 0);
        c_op[ch]  = 8'($urandom);
        c_msk[ch] = ($urandom_range(1) != 0) ? 8'hFF : 8'($urandom);
        c_lo[ch]  = 24'($urandom);
        c_hi[ch]  = ($urandom_range(4) == 0) ? 24'($urandom) : c_lo[ch] + 24'($urandom_range(4096));
        c_len[ch] = 4'($urandom);
        c_len_b[ch] = 8'(c_len[ch]);
      end
      j = $urandom_range(NUM_CH - 1);
      if ($urandom_range(3) == 0) begin
        f = $urandom;
      end else begin
        ad = (c_lo[j] <= c_hi[j]) ? c_lo[j] + 24'($urandom_range(int'(c_hi[j] - c_lo[j]))) : 24'($urandom);
        f = {c_op[j] ^ (8'($urandom) & ~c_msk[j]), ad};
      end
      tick(1);
      run_frame(f, 0, "random");
    end
  endtask

  task automatic test_reset_mid_pulse();
    int k;
    set_ch(0, 1, 8'h10, 8'hFF, 24'h000100, 24'h0001FF, 4'd15);
    for (int ch = 1; ch < NUM_CH; ch++) c_en[ch] = 1'b0;
    tick(1);
    send_frame(32'h10000150, 32, 0, k);
    tick(2);
    #2;
    checks++;
    if (trg_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse precondition: got trg0=%b, required 1", trg_a[0]);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_pulse");
    tick(2);
    rst_n = 1'b1;
    model_reset();
    tick(3);
    check_all_zero("after_mid_reset");
  endtask

  initial begin
    rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    arm_mode = 1'b0; rearm = 1'b0; hit_clr = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, 0, 8'h00, 8'h00, 24'h0, 24'h0, 4'd0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_window();
    test_mask();
    test_short_frame();
    test_one_shot();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptmch_trg_mc.md
Name: ptmch_trg_mc

Overview:
Multi-channel SPI NAND command pattern-match trigger. The block oversamples SPI_CS/SPI_CLK/SPI_MOSI in the CLK160M domain and captures the opcode+address header of each SPI frame. It compares the header against NUM_CH independently programmed channels, each with an opcode/mask and an address window. Per-channel trigger pulses have programmable length, optional one-shot arming, and saturating hit counters; the outputs feed the scope/LED trigger logic.

Parameters:
NUM_CH, 5, number of match channels
OP_W, 8, opcode width in bits
ADDR_W, 24, address width in bits
PLS_W, 4, pulse-length field width
CNT_W, 16, hit-counter width per channel
SYNC_STG, 2, synchroniser depth on the SPI inputs (minimum 2)

Ports:
CLK160M  in  1  system clock; only clock in the block
RESET_N  in  1  reset, asynchronous, active-low
SPI_CS  in  1  SPI chip select, active-low, asynchronous to CLK160M
SPI_CLK  in  1  SPI clock, mode 0, sampled as data
SPI_MOSI  in  1  SPI data, MSB first
CH_EN  in  NUM_CH  per-channel enable
CH_OPCODE  in  NUM_CH*OP_W  expected opcode, channel i at [i*OP_W +: OP_W]
CH_OPMASK  in  NUM_CH*OP_W  opcode compare mask; 1 = bit compared
CH_LOW_ADDR  in  NUM_CH*ADDR_W  inclusive lower address bound
CH_HIGH_ADDR  in  NUM_CH*ADDR_W  inclusive upper address bound
CH_PLS_LEN  in  NUM_CH*PLS_W  pulse length minus 1, in CLK160M cycles
ARM_MODE  in  1  0 = continuous, 1 = one-shot
REARM  in  1  one-cycle pulse; re-arms all channels
HIT_CNT_CLR  in  1  synchronous clear of all hit counters
TRG_PLS  out  NUM_CH  per-channel trigger pulse
TRG_ANY  out  1  OR of TRG_PLS
HIT_CNT  out  NUM_CH*CNT_W  saturating hit counts
FRAME_SHORT  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset values: TRG_PLS=0, TRG_ANY=0, HIT_CNT=0, FRAME_SHORT=0, armed=all 1, synchronisers CS=1/CLK=0/MOSI=0, shift register=0, bit count=0.
- The SPI inputs pass through SYNC_STG flops. One further register provides edge detection.
- SPI_CLK high and low phases must each last at least 3 CLK160M cycles. Faster SPI_CLK is out of spec.
- Falling edge of synced CS: bit count clears to 0 and the shift register clears.
- Each synced SPI_CLK rising edge while CS is low, with bit count < FRAME_W (FRAME_W = OP_W+ADDR_W): shift MOSI into the LSB and increment the bit count.
- Once the bit count reaches FRAME_W it holds. Later bits in the same frame are ignored, giving exactly one header per CS assertion.
- Cycle E is the cycle in which the FRAME_W-th edge is detected. Compare stage registered at E+1; TRG_PLS rises at E+2.
- Match condition for channel i: CH_EN[i], AND (armed[i] OR ARM_MODE=0), AND ((op XOR CH_OPCODE) AND CH_OPMASK)==0, AND low<=addr<=high (unsigned).
- If low > high, channel i never matches.
- Configuration inputs are sampled in cycle E+1 and must be static during a frame.
- Pulse: a match loads counter i with CH_PLS_LEN[i]. TRG_PLS[i] is high for CH_PLS_LEN[i]+1 cycles.
- A new match on a channel whose pulse is still active reloads its counter, extending the pulse.
- CS deassertion does not truncate an active pulse.
- Synced CS rising with 0 < bit count < FRAME_W: FRAME_SHORT is high for one cycle, no compare occurs, and the shift register clears.
- CS rising with bit count 0 or FRAME_W: no FRAME_SHORT.
- One-shot mode (ARM_MODE=1): a match on channel i clears armed[i] in cycle E+2.
- REARM sets all armed bits. If REARM and a clear occur in the same cycle, REARM wins.
- In continuous mode (ARM_MODE=0), the armed bits are ignored but still updated by REARM only.
- HIT_CNT[i] increments by 1 per match and saturates at all-ones. If HIT_CNT_CLR and an increment occur in the same cycle, the clear wins.
- TRG_ANY is combinational OR of the registered TRG_PLS.
- Reset asserted mid-frame or mid-pulse forces all reset values immediately.

Test Plan:
1. Ch0 opcode 0x10, mask 0xFF, window 0x000100–0x0001FF, PLS_LEN 15; send frame 0x10000150 -> TRG_PLS[0] high exactly 16 cycles from E+2, TRG_ANY matches, HIT_CNT[0]=1, other channels 0.
2. Same configuration, addresses 0x0000FF / 0x000100 / 0x0001FF / 0x000200 -> pulses only for 0x000100 and 0x0001FF; HIT_CNT[0]=2.
3. Ch1 opcode 0x00, mask 0xF0, window 0x000000–0xFFFFFF; frames 0x0F123456 and 0x1F123456 -> only the first fires TRG_PLS[1]. A low > high window on ch2 never fires.
4. CS raised after 20 bits -> FRAME_SHORT high 1 cycle, no TRG_PLS. The next full matching frame triggers normally.
5. ARM_MODE=1, two matching ch0 frames -> one pulse, HIT_CNT[0]=1. Then REARM plus a third frame -> pulse, HIT_CNT[0]=2. A second frame arriving during an active pulse in continuous mode extends the pulse to PLS_LEN+1 cycles from the second E+2.
6. CNT_W=2, five matches -> HIT_CNT[0]=3. HIT_CNT_CLR coincident with a match -> 0. RESET_N low mid-pulse -> TRG_PLS=0 immediately and all counters 0.
